// File: rtl/prog_seq_lock_pkg.sv
// Shared definitions for the programmable sequence lock: state encoding and
// the helper that sizes the down-counting timer.
package lock_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_CHECK    = 3'd2,
    S_UNLOCKED = 3'd3,
    S_LOCKOUT  = 3'd4,
    S_PROG     = 3'd5
  } state_t;

  // Bits needed to hold a count of 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prog_seq_lock_press_detect.sv
// Rising-edge press detection for the two debounced buttons. History resets
// high so a button already held when reset releases never counts as a press.
module press_detect (
  input  logic clk,
  input  logic rst,
  input  logic b0,
  input  logic b1,
  output logic sym0,
  output logic sym1,
  output logic clr
);

  logic b0_q;
  logic b1_q;
  logic rise0;
  logic rise1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b0_q <= 1'b1;
      b1_q <= 1'b1;
    end else begin
      b0_q <= b0;
      b1_q <= b1;
    end
  end

  assign rise0 = b0 & ~b0_q;
  assign rise1 = b1 & ~b1_q;

  // Both buttons rising on the same edge is the CLEAR gesture, not a symbol.
  assign sym0 = rise0 & ~rise1;
  assign sym1 = rise1 & ~rise0;
  assign clr  = rise0 & rise1;

endmodule

// File: rtl/prog_seq_lock.sv
// Two-button combination lock with run-time programmable code, failed-attempt
// lockout and a timed unlock window.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for the first symbol of an entry
// S_ENTRY    | collecting symbols until CODE_LEN have arrived
// S_CHECK    | single cycle comparing the entry with the stored code
// S_UNLOCKED | unlock window running; prog request moves to S_PROG
// S_LOCKOUT  | too many failures; all presses ignored until timer expires
// S_PROG     | collecting a new code; CLEAR aborts and keeps the old one
module prog_seq_lock
  import lock_pkg::*;
#(
  parameter int          CODE_LEN     = 5,
  parameter logic [31:0] DEFAULT_CODE = 32'b01011,
  parameter int          MAX_FAIL     = 3,
  parameter int          LOCKOUT_CYC  = 1000,
  parameter int          UNLOCK_CYC   = 100,
  localparam int         DW           = $clog2(CODE_LEN + 1),
  localparam int         FW           = $clog2(MAX_FAIL + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               b0,
  input  logic               b1,
  input  logic               prog,
  output logic               unlock,
  output logic               locked_out,
  output logic               prog_mode,
  output logic [STATE_W-1:0] state,
  output logic [DW-1:0]      digit_cnt,
  output logic [FW-1:0]      fail_cnt
);

  localparam int TW = width_of((LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC);

  state_t              st;
  logic [CODE_LEN-1:0] entry;
  logic [CODE_LEN-1:0] code;
  logic [TW-1:0]       timer;
  logic [DW-1:0]       dcnt;
  logic [FW-1:0]       fcnt;
  logic                unlock_q;
  logic                lock_q;
  logic                prog_q;

  logic                sym0;
  logic                sym1;
  logic                clr;
  logic                sym;
  logic [CODE_LEN-1:0] entry_sh;
  logic [DW-1:0]       dcnt_inc;
  logic                last_sym;
  logic [FW-1:0]       fail_inc;

  press_detect u_press (
    .clk  (clk),
    .rst  (rst),
    .b0   (b0),
    .b1   (b1),
    .sym0 (sym0),
    .sym1 (sym1),
    .clr  (clr)
  );

  // Newest symbol enters at the LSB, so the first symbol ends up in the MSB.
  assign sym      = sym0 | sym1;
  assign entry_sh = CODE_LEN'({entry, sym1});
  assign dcnt_inc = dcnt + DW'(1);
  assign last_sym = (dcnt_inc == DW'(CODE_LEN));
  assign fail_inc = fcnt + FW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      entry    <= '0;
      code     <= DEFAULT_CODE[CODE_LEN-1:0];
      timer    <= '0;
      dcnt     <= '0;
      fcnt     <= '0;
      unlock_q <= 1'b0;
      lock_q   <= 1'b0;
      prog_q   <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (sym) begin
            entry <= entry_sh;
            dcnt  <= dcnt_inc;
            st    <= last_sym ? S_CHECK : S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (clr) begin
            dcnt <= '0;
            st   <= S_IDLE;
          end else if (sym) begin
            entry <= entry_sh;
            dcnt  <= dcnt_inc;
            if (last_sym) st <= S_CHECK;
          end
        end

        S_CHECK: begin
          dcnt <= '0;
          if (entry == code) begin
            fcnt     <= '0;
            timer    <= TW'(UNLOCK_CYC - 1);
            unlock_q <= 1'b1;
            st       <= S_UNLOCKED;
          end else if (fail_inc == FW'(MAX_FAIL)) begin
            fcnt   <= fail_inc;
            timer  <= TW'(LOCKOUT_CYC - 1);
            lock_q <= 1'b1;
            st     <= S_LOCKOUT;
          end else begin
            fcnt <= fail_inc;
            st   <= S_IDLE;
          end
        end

        // A programming request wins over the window expiring on the same edge.
        S_UNLOCKED: begin
          if (prog) begin
            timer    <= '0;
            unlock_q <= 1'b0;
            prog_q   <= 1'b1;
            st       <= S_PROG;
          end else if (timer == '0) begin
            unlock_q <= 1'b0;
            st       <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_LOCKOUT: begin
          if (timer == '0) begin
            fcnt   <= '0;
            lock_q <= 1'b0;
            st     <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_PROG: begin
          if (clr) begin
            dcnt   <= '0;
            prog_q <= 1'b0;
            st     <= S_IDLE;
          end else if (sym) begin
            entry <= entry_sh;
            if (last_sym) begin
              code   <= entry_sh;
              dcnt   <= '0;
              prog_q <= 1'b0;
              st     <= S_IDLE;
            end else begin
              dcnt <= dcnt_inc;
            end
          end
        end

        default: begin
          st       <= S_IDLE;
          dcnt     <= '0;
          timer    <= '0;
          unlock_q <= 1'b0;
          lock_q   <= 1'b0;
          prog_q   <= 1'b0;
        end
      endcase
    end
  end

  assign state      = st;
  assign unlock     = unlock_q;
  assign locked_out = lock_q;
  assign prog_mode  = prog_q;
  assign digit_cnt  = dcnt;
  assign fail_cnt   = fcnt;

endmodule
